rr_req_arbiter: RTL and testbench

- Upstream request merger for the AXI_SIG ready/valid FIFO.
- Collects ID/ADDR/DATA requests from NUM_SRC independent source channels and grants one channel per cycle, round-robin.
- Presents the winner through a single registered output stage; m_* connects directly to the FIFO source side (in_AXI/svalid/sready).
- Also reports which source won, so downstream logic can route responses.

---
 rtl/rr_req_arbiter.sv | 115 +++++++++++
 tb/tb_rr_req_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/rr_req_arbiter.sv
// rtl/rr_req_arbiter.sv - round-robin merger of NUM_SRC request channels into one registered ready/valid stage
// The winning source is reported on m_src so responses can be routed back.
module rr_req_arbiter #(
  parameter int NUM_SRC    = 4,
  parameter int ID_WIDTH   = 3,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  localparam int SRC_W     = $clog2(NUM_SRC)
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [NUM_SRC-1:0]             s_valid,
  output logic [NUM_SRC-1:0]             s_ready,
  input  logic [NUM_SRC*ID_WIDTH-1:0]    s_id,
  input  logic [NUM_SRC*ADDR_WIDTH-1:0]  s_addr,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]  s_data,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [ID_WIDTH-1:0]            m_id,
  output logic [ADDR_WIDTH-1:0]          m_addr,
  output logic [DATA_WIDTH-1:0]          m_data,
  output logic [SRC_W-1:0]               m_src
);

  logic                  m_valid_q, m_valid_d;
  logic [ID_WIDTH-1:0]   m_id_q, m_id_d;
  logic [ADDR_WIDTH-1:0] m_addr_q, m_addr_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic [SRC_W-1:0]      m_src_q, m_src_d;
  logic [SRC_W-1:0]      last_grant_q, last_grant_d;

  logic                  load;
  logic                  found;
  logic [SRC_W-1:0]      win;
  logic [SRC_W-1:0]      cand;
  logic [ID_WIDTH-1:0]   sel_id;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;

  // Search starts just past the last winner and wraps, so the pointer only advances on a grant.
  always_comb begin
    load  = !m_valid_q || m_ready;
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      cand = SRC_W'((int'(last_grant_q) + k) % NUM_SRC);
      if (!found && s_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    sel_id   = '0;
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (win == SRC_W'(i)) begin
        sel_id   = s_id[i*ID_WIDTH +: ID_WIDTH];
        sel_addr = s_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data = s_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    s_ready      = '0;
    m_valid_d    = m_valid_q;
    m_id_d       = m_id_q;
    m_addr_d     = m_addr_q;
    m_data_d     = m_data_q;
    m_src_d      = m_src_q;
    last_grant_d = last_grant_q;
    if (load) begin
      if (found) begin
        s_ready[win] = 1'b1;
        m_valid_d    = 1'b1;
        m_id_d       = sel_id;
        m_addr_d     = sel_addr;
        m_data_d     = sel_data;
        m_src_d      = win;
        last_grant_d = win;
      end else begin
        m_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      m_valid_q    <= 1'b0;
      m_id_q       <= '0;
      m_addr_q     <= '0;
      m_data_q     <= '0;
      m_src_q      <= '0;
      last_grant_q <= SRC_W'(NUM_SRC - 1);
    end else begin
      m_valid_q    <= m_valid_d;
      m_id_q       <= m_id_d;
      m_addr_q     <= m_addr_d;
      m_data_q     <= m_data_d;
      m_src_q      <= m_src_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_id    = m_id_q;
  assign m_addr  = m_addr_q;
  assign m_data  = m_data_q;
  assign m_src   = m_src_q;

endmodule

// File: tb/tb_rr_req_arbiter.sv
// tb/tb_rr_req_arbiter.sv - scoreboard bench for rr_req_arbiter
module tb_rr_req_arbiter;

  localparam int NS = 4;
  localparam int IW = 3;
  localparam int AW = 32;
  localparam int DW = 32;

  logic              clk;
  logic              rstn;
  logic [NS-1:0]     s_valid;
  logic [NS-1:0]     s_ready;
  logic [NS*IW-1:0]  s_id;
  logic [NS*AW-1:0]  s_addr;
  logic [NS*DW-1:0]  s_data;
  logic              m_valid;
  logic              m_ready;
  logic [IW-1:0]     m_id;
  logic [AW-1:0]     m_addr;
  logic [DW-1:0]     m_data;
  logic [1:0]        m_src;

  rr_req_arbiter #(
    .NUM_SRC(NS), .ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
  ) dut (
    .clk(clk), .rstn(rstn),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_id(s_id), .s_addr(s_addr), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_id(m_id), .m_addr(m_addr), .m_data(m_data), .m_src(m_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [IW-1:0] id;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [1:0]    src;
  } exp_t;

  exp_t          exp_q[$];
  logic [IW-1:0] src_id   [NS];
  logic [AW-1:0] src_addr [NS];
  logic [DW-1:0] src_data [NS];

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic set_src(input int i, input logic [IW-1:0] id, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data);
    src_id[i]   = id;
    src_addr[i] = addr;
    src_data[i] = data;
    s_id[i*IW +: IW]   = id;
    s_addr[i*AW +: AW] = addr;
    s_data[i*DW +: DW] = data;
  endtask

  task automatic push_src(input int i);
    exp_t e;
    e.id   = src_id[i];
    e.addr = src_addr[i];
    e.data = src_data[i];
    e.src  = 2'(i);
    exp_q.push_back(e);
  endtask

  // One clock: drive inputs, check s_ready mid-cycle, return just after the edge.
  task automatic cycle(input logic [NS-1:0] sv, input logic mr, input logic [NS-1:0] exp_sr,
                       input string name);
    s_valid = sv;
    m_ready = mr;
    @(negedge clk);
    chk(name, {76'd0, s_ready}, {76'd0, exp_sr});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn    = 1'b0;
    s_valid = '0;
    m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_m_valid", {79'd0, m_valid}, 80'd0);
    chk("reset_m_fields", {m_id, m_addr, m_data, m_src}, '0);
    chk("reset_s_ready", {76'd0, s_ready}, 80'd0);
    rstn = 1'b1;
  endtask

  always @(negedge clk) begin
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_word: got src %0d data %0h expected no word", m_src, m_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("word", {m_id, m_addr, m_data, m_src}, {e.id, e.addr, e.data, e.src});
      end
    end
  end

  initial begin
    rstn    = 1'b0;
    s_valid = '0;
    m_ready = 1'b0;
    s_id    = '0;
    s_addr  = '0;
    s_data  = '0;
    for (int i = 0; i < NS; i++) set_src(i, IW'(i + 1), 32'h2000 + i, 32'hD0 + i);

    // single request from source 0
    do_reset();
    set_src(0, 3'd5, 32'h1000, 32'hA0);
    cycle(4'b0001, 1'b1, 4'b0001, "t1_grant");
    push_src(0);
    cycle(4'b0000, 1'b1, 4'b0000, "t1_idle");
    chk("t1_empty", {79'd0, m_valid}, 80'd0);
    set_src(0, 3'd1, 32'h2000, 32'hD0);

    // all sources valid: strict rotation, no bubble
    do_reset();
    for (int k = 0; k < 8; k++) begin
      cycle(4'b1111, 1'b1, 4'(1 << (k % 4)), "t2_rotate");
      push_src(k % 4);
    end
    cycle(4'b0000, 1'b1, 4'b0000, "t2_drain");

    // sparse requesters 1 and 3
    cycle(4'b1010, 1'b1, 4'b0010, "t3_g1");  push_src(1);
    cycle(4'b1010, 1'b1, 4'b1000, "t3_g3");  push_src(3);
    cycle(4'b1010, 1'b1, 4'b0010, "t3_g1b"); push_src(1);
    cycle(4'b1010, 1'b1, 4'b1000, "t3_g3b"); push_src(3);
    cycle(4'b0000, 1'b1, 4'b0000, "t3_drain");

    // backpressure hold of a source 2 word
    set_src(2, 3'd6, 32'h3000, 32'hDEADBEEF);
    cycle(4'b0100, 1'b1, 4'b0100, "t4_g2");
    push_src(2);
    for (int k = 0; k < 5; k++) begin
      cycle(4'b1111, 1'b0, 4'b0000, "t4_stall");
      chk("t4_hold", {m_valid, m_src, m_data}, {45'd0, 1'b1, 2'd2, 32'hDEADBEEF});
    end
    cycle(4'b1111, 1'b1, 4'b1000, "t4_release");
    push_src(3);
    cycle(4'b0000, 1'b1, 4'b0000, "t4_drain");

    // single source, toggling downstream ready
    for (int k = 0; k < 6; k++) begin
      set_src(1, 3'd2, 32'h4000, 32'h101 + (k + 1) / 2);
      if (k % 2 == 0) begin
        cycle(4'b0010, 1'b1, 4'b0010, "t5_take");
        push_src(1);
      end else begin
        cycle(4'b0010, 1'b0, 4'b0000, "t5_block");
      end
    end
    cycle(4'b0000, 1'b1, 4'b0000, "t5_drain");

    // reset with a word pending
    cycle(4'b0100, 1'b0, 4'b0100, "t6_g2");
    rstn = 1'b0;
    cycle(4'b1111, 1'b0, 4'b0000, "t6_in_reset");
    chk("t6_valid_clr", {79'd0, m_valid}, 80'd0);
    chk("t6_fields_clr", {m_id, m_addr, m_data, m_src}, '0);
    rstn = 1'b1;
    cycle(4'b1111, 1'b1, 4'b0001, "t6_first_g0");
    push_src(0);
    cycle(4'b0000, 1'b1, 4'b0000, "t6_drain");

    repeat (2) @(posedge clk);
    #1;
    chk("queue_empty", 80'(exp_q.size()), 80'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
